// File: rtl/rsfq_gate_nt.sv
// N-input clocked RSFQ gate model (OR / AND / XOR / threshold) on toggle-encoded pulses.
// Per-input storage loops are read out and cleared by each SFQ clock pulse.
module rsfq_gate_nt #(
    parameter int unsigned N    = 2,
    parameter int unsigned MODE = 0,
    parameter int unsigned K    = 2,
    parameter int unsigned CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in,
    input  logic          sfq_clk,
    output logic          out,
    output logic [CW-1:0] out_cnt,
    output logic [N-1:0]  pending,
    output logic          dup_err
);

    localparam int unsigned PW = $clog2(N + 1);

    // Reject illegal configurations at elaboration.
    generate
        if (N < 2 || N > 16 || MODE > 3 || (MODE == 3 && (K < 1 || K > N))) begin : g_bad_cfg
            $error("rsfq_gate_nt: illegal parameters N=%0d MODE=%0d K=%0d", N, MODE, K);
        end
    endgenerate

    logic [N-1:0]  in_q;
    logic          sclk_q;
    logic          armed;
    logic [N-1:0]  ev;
    logic [N-1:0]  eff;
    logic          sev;
    logic          dup;
    logic          result;
    logic [PW-1:0] pop;

    // Pulse detection and gate evaluation over the closing period's pulses.
    always_comb begin
        ev     = in ^ in_q;
        sev    = sfq_clk ^ sclk_q;
        eff    = pending | ev;
        dup    = |(pending & ev);
        pop    = '0;
        result = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            pop = pop + PW'(eff[i]);
        end
        case (MODE)
            0:       result = |eff;
            1:       result = &eff;
            2:       result = ^eff;
            default: result = (pop >= PW'(K));
        endcase
    end

    // First edge after reset only captures levels so held inputs create no pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q    <= '0;
            sclk_q  <= 1'b0;
            armed   <= 1'b0;
            pending <= '0;
            out     <= 1'b0;
            out_cnt <= '0;
            dup_err <= 1'b0;
        end else if (!armed) begin
            in_q   <= in;
            sclk_q <= sfq_clk;
            armed  <= 1'b1;
        end else begin
            in_q   <= in;
            sclk_q <= sfq_clk;
            if (dup) begin
                dup_err <= 1'b1;
            end
            if (sev) begin
                pending <= '0;
                if (result) begin
                    out     <= ~out;
                    out_cnt <= out_cnt + CW'(1);
                end
            end else begin
                pending <= pending | ev;
            end
        end
    end

endmodule
